key_serializer: RTL and testbench
=================================

Name: key_serializer

Overview:
- Read-side counterpart to the key-entry index counter. Once key entry is complete, it reads the stored key characters back out of the key buffer in index order.
- It serialises them into a fixed-length bit stream for the A5/1 register key-loading phase, under a valid/ready handshake.
- Short keys are zero-padded and over-long keys are truncated, so exactly KEY_BITS bits are always delivered.

Parameters:
- CHAR_WIDTH, 8: bits per stored key character.
- KEY_BITS, 64: total bits delivered per session; must be a multiple of CHAR_WIDTH.
- INDEX_WIDTH, 4: width of the key-length input and of the buffer read address.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  single-cycle request to begin a session; sampled in IDLE only.
- key_len  input  INDEX_WIDTH  number of characters entered (the final entry index); sampled on an accepted start.
- rd_addr  output  INDEX_WIDTH  key buffer read address.
- rd_en  output  1  key buffer read strobe.
- rd_data  input  CHAR_WIDTH  key buffer read data; valid exactly one cycle after rd_en.
- bit_out  output  1  current key bit.
- bit_valid  output  1  bit_out holds a valid bit.
- bit_ready  input  1  consumer accepts bit_out this cycle.
- busy  output  1  high from the cycle after an accepted start until DONE.
- done  output  1  one-cycle pulse after the last bit is accepted.

Behaviour:
- Reset values: rd_addr=0, rd_en=0, bit_out=0, bit_valid=0, busy=0, done=0. State=IDLE. Shift register, bit counter and char counter all 0.
- Derived constants:
  - NCHARS = KEY_BITS/CHAR_WIDTH.
  - eff_len = min(key_len, NCHARS), latched on an accepted start.
- IDLE:
  - start=1 latches eff_len, clears counters and goes to FETCH.
  - start in any other state is ignored.
- FETCH:
  - If char_cnt < eff_len: assert rd_en=1 for one cycle with rd_addr=char_cnt, then go to LOAD.
  - Otherwise load the shift register with all zeros (padding) and go to SHIFT directly; rd_en stays 0.
- LOAD: capture rd_data into the shift register, then go to SHIFT.
- SHIFT:
  - bit_valid=1 and bit_out = shift_reg[0]. Character 0 is sent first, LSB first within each character.
  - A bit transfers only when bit_valid & bit_ready. On transfer: shift right by one and increment bit_cnt.
  - After CHAR_WIDTH transfers of the current character, increment char_cnt:
    - if bit_cnt == KEY_BITS, go to DONE;
    - otherwise go to FETCH.
  - bit_ready=0 holds bit_out and all state unchanged; bit_valid stays high (no retraction).
- DONE: done=1 for one cycle, busy=0, then IDLE.
- Latency:
  - Start accepted at cycle 0, so the first bit is valid at cycle 3 (FETCH at 1, LOAD at 2, SHIFT at 3).
  - Each real character boundary adds a 2-cycle bubble with bit_valid=0. Each padding boundary adds a 1-cycle bubble.
  - With bit_ready held high and NCHARS=8 real characters: done pulses at cycle 3 + 64 + 7*2 = 81.
- Boundaries:
  - key_len=0: all KEY_BITS bits are 0 and rd_en is never asserted.
  - key_len > NCHARS (e.g. 12): only addresses 0..NCHARS-1 are read.
  - key_len may change after start with no effect on the session in progress.
  - start and reset together: reset wins.
  - Reset mid-session: immediate return to IDLE with reset values; no done pulse.
  - bit_cnt is wide enough to hold KEY_BITS without wrapping.

Test Plan:
- Full key: buffer = 0x01,0x02,...,0x08, key_len=8, start, bit_ready=1.
  - Required: first bits 1,0,0,0,0,0,0,0 then 0,1,0,... (LSB first).
  - Exactly 64 accepted bits; rd_addr sequence 0..7.
  - done single pulse at cycle 81; busy low afterwards.
- Short key: key_len=2, buffer[0]=0xFF, buffer[1]=0xA5.
  - Required: 8 ones, then 1,0,1,0,0,1,0,1, then 48 zeros.
  - rd_en asserted exactly twice; done after 64 accepted bits.
- Empty and over-long keys:
  - key_len=0: 64 zero bits, rd_en never high.
  - key_len=15: reads stop at addr 7; 64 bits total.
- Backpressure: random bit_ready with about 50% duty.
  - Bit stream identical to the bit_ready=1 run.
  - bit_out stable while bit_valid=1 and bit_ready=0; no bits dropped or duplicated.
- Reset and ignored start:
  - Assert reset after the 20th accepted bit: all outputs 0 in the same cycle, state IDLE, no done.
  - A new start then begins again from addr 0.
  - A start pulse while busy has no effect on the stream or the count.

Source files
------------

// File: rtl/key_serializer.sv
// Reads the stored key back out of the key buffer in index order and serialises it
// LSB-first into exactly KEY_BITS bits under a valid/ready handshake, zero-padding short keys.
module key_serializer #(
    parameter int CHAR_WIDTH  = 8,
    parameter int KEY_BITS    = 64,
    parameter int INDEX_WIDTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [INDEX_WIDTH-1:0] key_len,
    output logic [INDEX_WIDTH-1:0] rd_addr,
    output logic                   rd_en,
    input  logic [CHAR_WIDTH-1:0]  rd_data,
    output logic                   bit_out,
    output logic                   bit_valid,
    input  logic                   bit_ready,
    output logic                   busy,
    output logic                   done
);

    localparam int NCHARS = KEY_BITS / CHAR_WIDTH;
    localparam int CNT_W  = $clog2(NCHARS + 1);
    localparam int BIT_W  = $clog2(KEY_BITS + 1);
    localparam int POS_W  = $clog2(CHAR_WIDTH + 1);
    localparam logic [31:0] NCHARS_U = 32'(NCHARS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_e;

    state_e                state_q,    state_d;
    logic [CHAR_WIDTH-1:0] shift_q,    shift_d;
    logic [BIT_W-1:0]      bit_cnt_q,  bit_cnt_d;
    logic [CNT_W-1:0]      char_cnt_q, char_cnt_d;
    logic [POS_W-1:0]      pos_q,      pos_d;
    logic [CNT_W-1:0]      eff_len_q,  eff_len_d;
    logic [CNT_W-1:0]      start_len;

    // Over-long keys are clamped so reads never go past the last character that fits.
    always_comb begin
        if (32'(key_len) > NCHARS_U) begin
            start_len = CNT_W'(NCHARS);
        end else begin
            start_len = CNT_W'(key_len);
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        char_cnt_d = char_cnt_q;
        pos_d      = pos_q;
        eff_len_d  = eff_len_q;
        rd_en      = 1'b0;
        rd_addr    = '0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    eff_len_d  = start_len;
                    bit_cnt_d  = '0;
                    char_cnt_d = '0;
                    pos_d      = '0;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                if (char_cnt_q < eff_len_q) begin
                    rd_en   = 1'b1;
                    rd_addr = INDEX_WIDTH'(char_cnt_q);
                    state_d = S_LOAD;
                end else begin
                    shift_d = '0;
                    state_d = S_SHIFT;
                end
            end
            S_LOAD: begin
                shift_d = rd_data;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (bit_ready) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (pos_q == POS_W'(CHAR_WIDTH - 1)) begin
                        pos_d      = '0;
                        char_cnt_d = char_cnt_q + CNT_W'(1);
                        state_d    = (bit_cnt_d == BIT_W'(KEY_BITS)) ? S_DONE : S_FETCH;
                    end else begin
                        pos_d = pos_q + POS_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            char_cnt_q <= '0;
            pos_q      <= '0;
            eff_len_q  <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            char_cnt_q <= char_cnt_d;
            pos_q      <= pos_d;
            eff_len_q  <= eff_len_d;
        end
    end

    assign bit_valid = (state_q == S_SHIFT);
    assign bit_out   = bit_valid & shift_q[0];
    assign busy      = (state_q == S_FETCH) || (state_q == S_LOAD) || (state_q == S_SHIFT);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_key_serializer.sv
// Self-checking bench for key_serializer: directed and randomized sessions compared against
// a bit-stream model built directly from the key buffer contents and the padding/truncation rules.
module tb_key_serializer;

    localparam int CW = 8;
    localparam int KB = 64;
    localparam int IW = 4;
    localparam int NC = KB / CW;
    localparam int CYCLE_LIMIT = 2000;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [IW-1:0] key_len;
    logic [IW-1:0] rd_addr;
    logic          rd_en;
    logic [CW-1:0] rd_data;
    logic          bit_out;
    logic          bit_valid;
    logic          bit_ready;
    logic          busy;
    logic          done;

    logic [CW-1:0] mem [16];

    int total  = 0;
    int passed = 0;

    key_serializer #(.CHAR_WIDTH(CW), .KEY_BITS(KB), .INDEX_WIDTH(IW)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .key_len   (key_len),
        .rd_addr   (rd_addr),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    // Key buffer: data appears one cycle after the strobe; junk otherwise.
    always @(posedge clock) begin
        rd_data <= rd_en ? mem[rd_addr] : 8'($urandom);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int eff_of(input int klen);
        return (klen > NC) ? NC : klen;
    endfunction

    // Bit i of the session is bit (i % CW) of character i / CW, or 0 beyond the key.
    function automatic logic [63:0] model_stream(input int klen);
        logic [63:0] s;
        s = '0;
        for (int i = 0; i < KB; i++) begin
            if (i / CW < eff_of(klen)) s[i] = mem[i / CW][i % CW];
        end
        return s;
    endfunction

    // Cycle of the done pulse with bit_ready held high, start accepted at cycle 0.
    function automatic int model_done_cycle(input int klen);
        int t;
        t = 1;
        for (int c = 0; c < NC; c++) begin
            t += (c < eff_of(klen)) ? 2 : 1;
            t += CW;
        end
        return t;
    endfunction

    task automatic fill_mem_random();
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    endtask

    task automatic fill_mem_counting();
        fill_mem_random();
        for (int i = 0; i < NC; i++) mem[i] = 8'(i + 1);
    endtask

    task automatic run_session(input int klen, input int ready_pct, input int abort_at,
                               input bit poke_start);
        logic [63:0] got;
        int          nacc;
        int          nrd;
        int          ndone;
        int          done_cyc;
        int          cyc;
        bit          held;
        logic        held_bit;
        bit          finished;
        bit          rdy;

        got = '0; nacc = 0; nrd = 0; ndone = 0; done_cyc = -1;
        held = 1'b0; held_bit = 1'b0; finished = 1'b0;

        @(negedge clock);
        key_len = IW'(klen);
        start   = 1'b1;
        @(negedge clock);
        start   = 1'b0;
        key_len = IW'($urandom);
        cyc     = 1;
        check("busy_after_start", 64'(busy), 64'(1));

        while (!finished && cyc < CYCLE_LIMIT) begin
            if (abort_at >= 0 && nacc == abort_at) begin
                reset     = 1'b1;
                bit_ready = 1'b0;
                #1;
                check("reset_outputs", 64'({rd_addr, rd_en, bit_out, bit_valid, busy, done}), 64'(0));
                check("abort_no_done", 64'(ndone), 64'(0));
                repeat (3) begin
                    @(negedge clock);
                    check("reset_hold_done", 64'(done), 64'(0));
                end
                reset = 1'b0;
                return;
            end

            if (held) begin
                check("hold_valid", 64'(bit_valid), 64'(1));
                check("hold_bit", 64'(bit_out), 64'(held_bit));
            end
            if (rd_en) begin
                check("rd_addr", 64'(rd_addr), 64'(nrd));
                nrd++;
            end
            if (done) begin
                ndone++;
                done_cyc = cyc;
                finished = 1'b1;
                check("busy_in_done", 64'(busy), 64'(0));
            end

            if (poke_start && cyc == 30) begin
                start   = 1'b1;
                key_len = '0;
            end else begin
                start = 1'b0;
            end

            rdy       = ($urandom_range(99) < ready_pct);
            bit_ready = rdy;
            held      = bit_valid && !rdy;
            held_bit  = bit_out;
            if (bit_valid && rdy) begin
                if (nacc < KB) got[nacc] = bit_out;
                nacc++;
            end

            if (!finished) begin
                @(negedge clock);
                cyc++;
            end
        end

        start = 1'b0;
        if (!finished) check("timeout", 64'(0), 64'(1));

        @(negedge clock);
        check("done_single_pulse", 64'(done), 64'(0));
        check("busy_after_done", 64'(busy), 64'(0));
        check("bits_accepted", 64'(nacc), 64'(KB));
        check("stream", got, model_stream(klen));
        check("rd_count", 64'(nrd), 64'(eff_of(klen)));
        check("done_pulses", 64'(ndone), 64'(1));
        if (ready_pct >= 100) check("done_cycle", 64'(done_cyc), 64'(model_done_cycle(klen)));
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        key_len   = '0;
        bit_ready = 1'b0;
        fill_mem_counting();

        repeat (2) @(negedge clock);
        check("reset_state", 64'({rd_addr, rd_en, bit_out, bit_valid, busy, done}), 64'(0));
        reset = 1'b0;
        @(negedge clock);
        check("idle_state", 64'({rd_addr, rd_en, bit_out, bit_valid, busy, done}), 64'(0));

        // Start coinciding with reset must be ignored.
        reset   = 1'b1;
        start   = 1'b1;
        key_len = 4'd8;
        @(negedge clock);
        check("reset_beats_start", 64'(busy), 64'(0));
        reset = 1'b0;
        start = 1'b0;
        @(negedge clock);
        check("idle_after_reset_start", 64'({busy, rd_en, bit_valid}), 64'(0));

        // Full key 0x01..0x08 with bit_ready always high.
        run_session(8, 100, -1, 1'b0);

        // Short key.
        fill_mem_random();
        mem[0] = 8'hFF;
        mem[1] = 8'hA5;
        run_session(2, 100, -1, 1'b0);

        // Empty and over-long keys.
        run_session(0, 100, -1, 1'b0);
        fill_mem_random();
        run_session(15, 100, -1, 1'b0);

        // Backpressure on the counting key.
        fill_mem_counting();
        run_session(8, 50, -1, 1'b0);

        // Randomized sessions.
        for (int n = 0; n < 4; n++) begin
            fill_mem_random();
            run_session(int'($urandom_range(15)), int'($urandom_range(100, 30)), -1, 1'b0);
        end

        // Reset after the 20th accepted bit, then a clean restart from address 0.
        fill_mem_counting();
        run_session(8, 100, 20, 1'b0);
        run_session(8, 100, -1, 1'b0);

        // A start pulse mid-session must not disturb the stream.
        fill_mem_random();
        run_session(6, 70, -1, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
